// File: rtl/rns_mod_reduce_ctrl.sv
// Binary-to-residue reduction front end for an RNS channel.
// Restoring shift-subtract: one quotient bit per clock.
module rns_mod_reduce_ctrl #(
  parameter int DW = 8
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          in_valid,
  output logic          in_ready,
  input  logic [DW-1:0] x,
  input  logic [3:0]    m,
  output logic          out_valid,
  input  logic          out_ready,
  output logic [3:0]    res,
  output logic [DW-1:0] quo,
  output logic          err
);

  localparam int MW = 4;
  localparam int CW = (DW > 1) ? $clog2(DW) : 1;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_t;

  state_t          state_q, state_d;
  logic [DW-1:0]   xr_q, xr_d;
  logic [MW-1:0]   mr_q, mr_d;
  logic [MW-1:0]   r_q, r_d;
  logic [DW-1:0]   quo_q, quo_d;
  logic [CW-1:0]   cnt_q, cnt_d;
  logic            err_q, err_d;

  logic [MW:0]     t;
  logic [MW-1:0]   sub;
  logic            ge;

  // One partial remainder step: shift in next bit, trial subtract
  always_comb begin
    t   = {r_q, xr_q[cnt_q]};
    ge  = t[MW] | (t[MW-1:0] >= mr_q);
    sub = t[MW-1:0] - mr_q;
  end

  // State and datapath registers
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      xr_q    <= '0;
      mr_q    <= '0;
      r_q     <= '0;
      quo_q   <= '0;
      cnt_q   <= '0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      xr_q    <= xr_d;
      mr_q    <= mr_d;
      r_q     <= r_d;
      quo_q   <= quo_d;
      cnt_q   <= cnt_d;
      err_q   <= err_d;
    end
  end

  // Next-state decode
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      IDLE: begin
        if (in_valid)
          state_d = (m == '0) ? DONE : RUN;
      end
      RUN: begin
        if (cnt_q == '0)
          state_d = DONE;
      end
      DONE: begin
        if (out_ready)
          state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  // Datapath update: capture on accept, one bit per RUN cycle
  always_comb begin
    xr_d  = xr_q;
    mr_d  = mr_q;
    r_d   = r_q;
    quo_d = quo_q;
    cnt_d = cnt_q;
    err_d = err_q;
    unique case (state_q)
      IDLE: begin
        if (in_valid) begin
          xr_d  = x;
          mr_d  = m;
          r_d   = '0;
          quo_d = '0;
          cnt_d = CW'(DW - 1);
          err_d = (m == '0);
        end
      end
      RUN: begin
        r_d          = ge ? sub : t[MW-1:0];
        quo_d[cnt_q] = ge;
        if (cnt_q != '0)
          cnt_d = cnt_q - CW'(1);
      end
      DONE: begin
      end
      default: begin
      end
    endcase
  end

  // Handshake and result outputs come straight from registers
  always_comb begin
    in_ready  = (state_q == IDLE);
    out_valid = (state_q == DONE);
    res       = r_q;
    quo       = quo_q;
    err       = err_q;
  end

endmodule

// File: tb/tb_rns_mod_reduce_ctrl.sv
// Directed bench for rns_mod_reduce_ctrl (DW=8).
// Inputs driven #1 after rising edge; outputs sampled there too.
module tb_rns_mod_reduce_ctrl;

  localparam int DW = 8;

  logic          clk;
  logic          rst_n;
  logic          in_valid;
  logic          in_ready;
  logic [DW-1:0] x;
  logic [3:0]    m;
  logic          out_valid;
  logic          out_ready;
  logic [3:0]    res;
  logic [DW-1:0] quo;
  logic          err;

  int n_pass;
  int n_total;

  rns_mod_reduce_ctrl #(.DW(DW)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .x         (x),
    .m         (m),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .res       (res),
    .quo       (quo),
    .err       (err)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag,
                     input logic [31:0] obs,
                     input logic [31:0] exp_v);
    n_total++;
    assert (obs === exp_v) n_pass++;
    else $error("FAIL %s observed=%0d expected=%0d",
                tag, obs, exp_v);
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Accept one operand, wait for the result, check it.
  // xfer: leave out_ready high so the result is taken.
  // hold: keep in_valid asserted afterwards.
  task automatic run_op(input string tag,
                        input logic [DW-1:0] xv,
                        input logic [3:0] mv,
                        input logic [3:0] e_res,
                        input logic [DW-1:0] e_quo,
                        input logic e_err,
                        input bit hold,
                        input bit xfer);
    int n;
    int e_lat;
    e_lat = (mv == 4'd0) ? 1 : DW + 1;
    chk({tag, ".in_ready"}, 32'(in_ready), 32'd1);
    x = xv;
    m = mv;
    in_valid = 1'b1;
    out_ready = xfer;
    tick();
    if (!hold) in_valid = 1'b0;
    n = 1;
    while (!out_valid && n < 50) begin
      tick();
      n++;
    end
    chk({tag, ".lat"}, 32'(n), 32'(e_lat));
    chk({tag, ".res"}, 32'(res), 32'(e_res));
    chk({tag, ".quo"}, 32'(quo), 32'(e_quo));
    chk({tag, ".err"}, 32'(err), 32'(e_err));
    if (xfer) begin
      tick();
      chk({tag, ".xfer_ov"}, 32'(out_valid), 32'd0);
      chk({tag, ".xfer_ir"}, 32'(in_ready), 32'd1);
    end
  endtask

  initial begin
    logic [DW-1:0] rx;
    logic [3:0]    e_r;
    logic [DW-1:0] e_q;
    n_pass = 0;
    n_total = 0;
    rst_n = 1'b0;
    in_valid = 1'b0;
    out_ready = 1'b1;
    x = '0;
    m = '0;
    #12;
    chk("rst.in_ready", 32'(in_ready), 32'd1);
    chk("rst.out_valid", 32'(out_valid), 32'd0);
    chk("rst.res", 32'(res), 32'd0);
    chk("rst.quo", 32'(quo), 32'd0);
    chk("rst.err", 32'(err), 32'd0);
    rst_n = 1'b1;
    tick();

    run_op("x200m7", 8'd200, 4'd7, 4'd4, 8'd28, 1'b0, 0, 1);
    run_op("x255m15", 8'd255, 4'd15, 4'd0, 8'd17, 1'b0, 0, 1);
    run_op("x13m14", 8'd13, 4'd14, 4'd13, 8'd0, 1'b0, 0, 1);
    run_op("x173m1", 8'd173, 4'd1, 4'd0, 8'd173, 1'b0, 0, 1);
    run_op("x0m5", 8'd0, 4'd5, 4'd0, 8'd0, 1'b0, 0, 1);
    run_op("x99m0", 8'd99, 4'd0, 4'd0, 8'd0, 1'b1, 0, 1);
    run_op("x9m4", 8'd9, 4'd4, 4'd1, 8'd2, 1'b0, 0, 1);

    // Backpressure with noisy inputs
    run_op("bp", 8'd100, 4'd9, 4'd1, 8'd11, 1'b0, 0, 0);
    for (int i = 0; i < 20; i++) begin
      x = DW'($urandom_range(0, 255));
      m = 4'($urandom_range(0, 15));
      in_valid = ~in_valid;
      tick();
      chk("bp.res", 32'(res), 32'd1);
      chk("bp.quo", 32'(quo), 32'd11);
      chk("bp.in_ready", 32'(in_ready), 32'd0);
      chk("bp.out_valid", 32'(out_valid), 32'd1);
    end
    in_valid = 1'b0;
    out_ready = 1'b1;
    tick();
    chk("bp.rel_ov", 32'(out_valid), 32'd0);
    chk("bp.rel_ir", 32'(in_ready), 32'd1);

    // Asynchronous reset in the middle of RUN
    x = 8'd77;
    m = 4'd5;
    in_valid = 1'b1;
    tick();
    in_valid = 1'b0;
    tick();
    tick();
    tick();
    chk("ar.in_run", 32'(in_ready), 32'd0);
    #2;
    rst_n = 1'b0;
    #1;
    chk("ar.in_ready", 32'(in_ready), 32'd1);
    chk("ar.out_valid", 32'(out_valid), 32'd0);
    chk("ar.res", 32'(res), 32'd0);
    chk("ar.quo", 32'(quo), 32'd0);
    chk("ar.err", 32'(err), 32'd0);
    #3;
    rst_n = 1'b1;
    tick();
    run_op("x50m6", 8'd50, 4'd6, 4'd2, 8'd8, 1'b0, 0, 1);

    // Sweep every modulus, in_valid held between operands
    for (int mi = 0; mi < 16; mi++) begin
      rx = DW'($urandom_range(0, 255));
      if (mi == 0) begin
        e_r = 4'd0;
        e_q = '0;
      end else begin
        e_r = 4'(rx % DW'(mi));
        e_q = rx / DW'(mi);
      end
      run_op($sformatf("sw.m%0d", mi), rx, 4'(mi),
             e_r, e_q, (mi == 0), 1, 1);
    end
    in_valid = 1'b0;
    tick();

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
